// File: rtl/multiciclo_control_fsm.sv
// Multi-cycle control sequencer for the Fase-series MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module multiciclo_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       Opcode,
    input  logic             Z,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegisterWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    logic [3:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             waiting, timeout, retire;

    always_comb begin
        waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                  && !mem_ready;
        // Expires on the WAIT_LIMIT-th stalled cycle; a ready in that cycle still completes.
        timeout = waiting && (wait_q == WAIT_LAST);
        state_d = state_q;
        error_d = error_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default: begin
                state_d = S_HALT;
                error_d = 1'b1;
            end
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    always_comb begin
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemToReg      = 1'b0;
        RegisterWrite = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 3'b000;
        PCSource      = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = !timeout;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                ALUSrcB = 2'b01;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = !timeout;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegisterWrite = 1'b1;
                MemToReg      = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = !timeout;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            S_ALUWB: begin
                RegisterWrite = 1'b1;
                RegDst        = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                PCWrite  = Z;
            end
            S_ADDIWB: RegisterWrite = 1'b1;
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign error       = error_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multiciclo_control_fsm.sv
// Directed bench for multiciclo_control_fsm: state walk and control word per instruction,
// memory stalls, timeout, illegal opcode and asynchronous reset.
module tb_multiciclo_control_fsm;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  Opcode;
    logic        Z;
    logic        mem_ready;
    logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, RegDst, MemToReg, RegisterWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOp;
    logic [1:0]  PCSource;
    logic [3:0]  state;
    logic        halted;
    logic        error;
    logic [31:0] instr_count;
    logic [15:0] ctl;

    int unsigned nvec;
    int unsigned nerr;

    multiciclo_control_fsm #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Opcode(Opcode), .Z(Z),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegisterWrite(RegisterWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .halted(halted), .error(error),
        .instr_count(instr_count)
    );

    // {PCWrite,IRWrite,MemRead,MemWrite, IorD,RegDst,MemToReg,RegisterWrite, ALUSrcA,ALUSrcB,ALUOp,PCSource}
    assign ctl = {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegDst, MemToReg, RegisterWrite,
                  ALUSrcA, ALUSrcB, ALUOp, PCSource};

    localparam logic [15:0] C_NONE  = 16'b0000_0000_0000_0000;
    localparam logic [15:0] C_FET_R = 16'b1110_0000_0010_0000;
    localparam logic [15:0] C_FET_W = 16'b0010_0000_0010_0000;
    localparam logic [15:0] C_DEC   = 16'b0000_0000_0110_0000;
    localparam logic [15:0] C_EXE   = 16'b0000_0000_1000_1000;
    localparam logic [15:0] C_ALUWB = 16'b0000_0101_0000_0000;
    localparam logic [15:0] C_MADR  = 16'b0000_0000_1100_0000;
    localparam logic [15:0] C_MRD   = 16'b0010_1000_0000_0000;
    localparam logic [15:0] C_MWB   = 16'b0000_0011_0000_0000;
    localparam logic [15:0] C_MWR   = 16'b0001_1000_0000_0000;
    localparam logic [15:0] C_BR1   = 16'b1000_0000_1000_0101;
    localparam logic [15:0] C_BR0   = 16'b0000_0000_1000_0101;
    localparam logic [15:0] C_AEX   = 16'b0000_0000_1100_0000;
    localparam logic [15:0] C_AWB   = 16'b0000_0001_0000_0000;
    localparam logic [15:0] C_JMP   = 16'b1000_0000_0000_0010;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [3:0] st, input logic [15:0] c);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nerr = 0;
        rst_n = 1'b0; start = 1'b0; Opcode = OP_R; Z = 1'b0; mem_ready = 1'b0;
        #3;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.ctl", 32'(ctl), 32'(C_NONE));
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.error", 32'(error), 32'd0);
        chk("rst.count", instr_count, 32'd0);

        // R-type
        tick(); rst_n = 1'b1; start = 1'b1; mem_ready = 1'b1; Opcode = OP_R;
        look("r.idle", 4'd0, C_NONE); tick(); start = 1'b0;
        look("r.fetch", 4'd1, C_FET_R); tick();
        look("r.dec", 4'd2, C_DEC); tick();
        look("r.exec", 4'd7, C_EXE); tick();
        look("r.wb", 4'd8, C_ALUWB);
        chk("r.count_pre", instr_count, 32'd0); tick();

        // lw
        Opcode = OP_LW;
        look("lw.fetch", 4'd1, C_FET_R); chk("r.count", instr_count, 32'd1); tick();
        look("lw.dec", 4'd2, C_DEC); tick();
        look("lw.madr", 4'd3, C_MADR); tick();
        look("lw.mrd", 4'd4, C_MRD); tick();
        look("lw.mwb", 4'd5, C_MWB); tick();

        // sw
        Opcode = OP_SW;
        look("sw.fetch", 4'd1, C_FET_R); chk("lw.count", instr_count, 32'd2); tick();
        look("sw.dec", 4'd2, C_DEC); tick();
        look("sw.madr", 4'd3, C_MADR); tick();
        look("sw.mwr", 4'd6, C_MWR); tick();

        // beq taken / not taken
        Opcode = OP_BEQ; Z = 1'b1;
        look("beq1.fetch", 4'd1, C_FET_R); chk("sw.count", instr_count, 32'd3); tick();
        look("beq1.dec", 4'd2, C_DEC); tick();
        look("beq1.br", 4'd9, C_BR1); tick();
        Z = 1'b0;
        look("beq0.fetch", 4'd1, C_FET_R); chk("beq1.count", instr_count, 32'd4); tick();
        look("beq0.dec", 4'd2, C_DEC); tick();
        look("beq0.br", 4'd9, C_BR0); tick();

        // addi
        Opcode = OP_ADDI;
        look("addi.fetch", 4'd1, C_FET_R); chk("beq0.count", instr_count, 32'd5); tick();
        look("addi.dec", 4'd2, C_DEC); tick();
        look("addi.ex", 4'd10, C_AEX); tick();
        look("addi.wb", 4'd11, C_AWB); tick();

        // j
        Opcode = OP_J;
        look("j.fetch", 4'd1, C_FET_R); chk("addi.count", instr_count, 32'd6); tick();
        look("j.dec", 4'd2, C_DEC); tick();
        look("j.jump", 4'd12, C_JMP); tick();

        // fetch stall, then lw that times out in MEMRD
        Opcode = OP_LW; mem_ready = 1'b0;
        chk("j.count", instr_count, 32'd7);
        for (int i = 0; i < 3; i++) begin
            look("stall.fetch", 4'd1, C_FET_W); tick();
        end
        mem_ready = 1'b1;
        look("stall.done", 4'd1, C_FET_R); tick();
        look("to.dec", 4'd2, C_DEC); tick();
        look("to.madr", 4'd3, C_MADR); mem_ready = 1'b0; tick();
        for (int i = 0; i < 15; i++) begin
            if (i < 14) begin
                look("to.mrd", 4'd4, C_MRD);
            end else begin
                #1;
                chk("to.last.state", 32'(state), 32'd4);
                chk("to.last.error", 32'(error), 32'd0);
            end
            tick();
        end
        #1;
        chk("to.halt.state", 32'(state), 32'd13);
        chk("to.halt.halted", 32'(halted), 32'd1);
        chk("to.halt.error", 32'(error), 32'd1);
        chk("to.halt.ctl", 32'(ctl), 32'(C_NONE));
        chk("to.halt.count", instr_count, 32'd7);
        start = 1'b1; mem_ready = 1'b1;
        repeat (3) tick();
        #1;
        chk("halt.sticky.state", 32'(state), 32'd13);
        chk("halt.sticky.error", 32'(error), 32'd1);

        // completion on the limit cycle wins over timeout
        tick(); #1; rst_n = 1'b0; #2; rst_n = 1'b1;
        chk("rst2.count", instr_count, 32'd0);
        start = 1'b1; mem_ready = 1'b0; Opcode = OP_J;
        tick(); start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            look("lim.fetch", 4'd1, C_FET_W); tick();
        end
        mem_ready = 1'b1;
        look("lim.ready", 4'd1, C_FET_R); tick();
        look("lim.dec", 4'd2, C_DEC); tick();
        look("lim.jump", 4'd12, C_JMP); tick();

        // illegal opcode
        Opcode = OP_BAD;
        look("ill.fetch", 4'd1, C_FET_R); chk("lim.count", instr_count, 32'd1); tick();
        look("ill.dec", 4'd2, C_DEC); tick();
        #1;
        chk("ill.state", 32'(state), 32'd13);
        chk("ill.halted", 32'(halted), 32'd1);
        chk("ill.error", 32'(error), 32'd1);
        chk("ill.count", instr_count, 32'd1);

        // asynchronous reset between clock edges
        tick(); #2; rst_n = 1'b0; #1;
        chk("arst.state", 32'(state), 32'd0);
        chk("arst.ctl", 32'(ctl), 32'(C_NONE));
        chk("arst.halted", 32'(halted), 32'd0);
        chk("arst.error", 32'(error), 32'd0);
        chk("arst.count", instr_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
